dpram_data_arbiter: RTL and testbench



---
 rtl/dpram_data_arbiter.sv | 133 +++++++++++++
 tb/tb_dpram_data_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dpram_data_arbiter.sv
// Round-robin arbiter sharing the dual-port RAM data port between two masters,
// with bounded locked bursts and registered read data / rvalid strobes.
module dpram_data_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic              m0_lock_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic              m1_lock_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t             state_q;
  logic               last_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               m0_rvalid_q;
  logic               m1_rvalid_q;
  logic [DATA_W-1:0]  m0_rdata_q;
  logic [DATA_W-1:0]  m1_rdata_q;

  logic acc0_s;
  logic acc1_s;
  logic cap_s;

  assign acc0_s = (state_q == OWN0) && m0_req_i;
  assign acc1_s = (state_q == OWN1) && m1_req_i;
  assign cap_s  = (cnt_q == CNT_W'(MAX_BURST - 1));

  assign m0_gnt_o    = acc0_s;
  assign m1_gnt_o    = acc1_s;
  assign m0_rvalid_o = m0_rvalid_q;
  assign m1_rvalid_o = m1_rvalid_q;
  assign m0_rdata_o  = m0_rdata_q;
  assign m1_rdata_o  = m1_rdata_q;

  // RAM port mux; writes are gated off during reset so an in-flight access cannot land
  always_comb begin
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    if (acc0_s) begin
      ram_we_o   = m0_we_i & ~rst_i;
      ram_addr_o = m0_addr_i;
      ram_data_o = m0_wdata_i;
    end else if (acc1_s) begin
      ram_we_o   = m1_we_i & ~rst_i;
      ram_addr_o = m1_addr_i;
      ram_data_o = m1_wdata_i;
    end else begin
      ram_we_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // On a tie the master that did not own last wins
          if (m0_req_i && (!m1_req_i || last_q)) begin
            state_q <= OWN0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (m1_req_i) begin
            state_q <= OWN1;
            last_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        OWN0: begin
          if (m0_req_i) begin
            cnt_q       <= cnt_q + CNT_W'(1);
            m0_rvalid_q <= 1'b1;
            if (!m0_we_i) m0_rdata_q <= ram_data_i;
            if (!m0_lock_i || cap_s) state_q <= IDLE;
          end else begin
            state_q <= IDLE;
          end
        end
        OWN1: begin
          if (m1_req_i) begin
            cnt_q       <= cnt_q + CNT_W'(1);
            m1_rvalid_q <= 1'b1;
            if (!m1_we_i) m1_rdata_q <= ram_data_i;
            if (!m1_lock_i || cap_s) state_q <= IDLE;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_data_arbiter.sv
// Directed self-checking bench for dpram_data_arbiter with a behavioural
// 256-word RAM model on the data port.
module tb_dpram_data_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [31:0] mem [0:255];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dpram_data_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_wdata),
    .ram_data_i(ram_rdata)
  );

  // Combinational-read, synchronous-write RAM model (word addressed)
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk) if (ram_we) mem[ram_addr[9:2]] <= ram_wdata;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    n_chk++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b%b want 00", m0_gnt, m1_gnt); end
    n_chk++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b%b want 00", m0_rvalid, m1_rvalid); end
    n_chk++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0", m0_rdata, m1_rdata); end
    n_chk++; if (ram_we !== 1'b0 || ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_ram: got we=%b a=%h d=%h want 0", ram_we, ram_addr, ram_wdata); end
    m0_req = 1'b1;
    m1_req = 1'b1;
    cyc();
    n_chk++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_req_gnt: got %b%b want 00", m0_gnt, m1_gnt); end
    rst = 1'b0;
    cyc();
    n_chk++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_first_tie: got m0=%b m1=%b want m0=1 m1=0", m0_gnt, m1_gnt); end
    cyc();
    m0_req = 1'b0;
    m1_req = 1'b0;
    n_chk++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_first_rvalid: got v=%b d=%h want v=1 d=0", m0_rvalid, m0_rdata); end
    cyc();
  endtask

  task automatic test_single_read();
    m1_req  = 1'b1;
    m1_we   = 1'b0;
    m1_addr = 32'h100;
    n_chk++; if (m1_gnt !== 1'b0) begin n_fail++; $display("FAIL sr_gnt_t: got %b want 0", m1_gnt); end
    cyc();
    n_chk++; if (m1_gnt !== 1'b1 || ram_addr !== 32'h100 || ram_we !== 1'b0) begin n_fail++; $display("FAIL sr_gnt_t1: got g=%b a=%h we=%b want g=1 a=100 we=0", m1_gnt, ram_addr, ram_we); end
    cyc();
    m1_req = 1'b0;
    n_chk++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sr_rdata: got v=%b d=%h want v=1 d=deadbeef", m1_rvalid, m1_rdata); end
    n_chk++; if (m1_gnt !== 1'b0 || ram_addr !== 32'h0) begin n_fail++; $display("FAIL sr_idle: got g=%b a=%h want g=0 a=0", m1_gnt, ram_addr); end
    cyc();
    n_chk++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL sr_rvalid_pulse: got %b want 0", m1_rvalid); end
  endtask

  task automatic test_round_robin();
    logic e0, e1, v0, v1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      e0 = (i % 4 == 1);
      e1 = (i % 4 == 3);
      v0 = (i % 4 == 2);
      v1 = (i % 4 == 0);
      n_chk++; if (m0_gnt !== e0 || m1_gnt !== e1) begin n_fail++; $display("FAIL rr_gnt cyc %0d: got %b%b want %b%b", i, m0_gnt, m1_gnt, e0, e1); end
      n_chk++; if (m0_rvalid !== v0 || m1_rvalid !== v1) begin n_fail++; $display("FAIL rr_rvalid cyc %0d: got %b%b want %b%b", i, m0_rvalid, m1_rvalid, v0, v1); end
      n_chk++; if (m0_gnt === 1'b1 && m1_gnt === 1'b1) begin n_fail++; $display("FAIL rr_both_gnt cyc %0d: got 11 want not both", i); end
      if (v0) begin
        n_chk++; if (m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rr_rdata0 cyc %0d: got %h want deadbeef", i, m0_rdata); end
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    cyc();
  endtask

  task automatic test_write_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'h12345678;
    cyc();
    n_chk++; if (m0_gnt !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 32'h12345678 || ram_addr !== 32'h20) begin n_fail++; $display("FAIL wr_port: got g=%b we=%b a=%h d=%h want 1 1 20 12345678", m0_gnt, ram_we, ram_addr, ram_wdata); end
    cyc();
    m0_req = 1'b0;
    n_chk++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rdata_hold: got v=%b d=%h want v=1 d=deadbeef", m0_rvalid, m0_rdata); end
    n_chk++; if (mem[8] !== 32'h12345678) begin n_fail++; $display("FAIL wr_mem: got %h want 12345678", mem[8]); end
    cyc();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h22;
    cyc();
    n_chk++; if (m0_gnt !== 1'b1 || ram_addr !== 32'h22) begin n_fail++; $display("FAIL rd_addr: got g=%b a=%h want g=1 a=22", m0_gnt, ram_addr); end
    cyc();
    m0_req = 1'b0;
    n_chk++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h12345678) begin n_fail++; $display("FAIL rd_aligned: got v=%b d=%h want v=1 d=12345678", m0_rvalid, m0_rdata); end
    cyc();
  endtask

  task automatic test_locked_burst();
    logic [10:0] g0m, g1m, rv1m, rv0m;
    int n1, nrv;
    g0m  = 11'b000_0100_0000;
    g1m  = 11'b011_0001_1110;
    rv1m = 11'b110_0011_1100;
    rv0m = 11'b000_1000_0000;
    n1   = 0;
    nrv  = 0;
    for (int k = 0; k < 6; k++) mem[k] = 32'hA000_0000 + k;
    m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b1; m1_addr = 32'h0;
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 32'h100;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (g1m[i-1]) begin
        n1++;
        m1_addr = n1 * 4;
        m1_lock = (n1 < 5);
        m1_req  = (n1 < 6);
      end
      if (g0m[i-1]) m0_req = 1'b0;
      n_chk++; if (m0_gnt !== g0m[i] || m1_gnt !== g1m[i]) begin n_fail++; $display("FAIL lb_gnt cyc %0d: got %b%b want %b%b", i, m0_gnt, m1_gnt, g0m[i], g1m[i]); end
      n_chk++; if (m1_rvalid !== rv1m[i] || m0_rvalid !== rv0m[i]) begin n_fail++; $display("FAIL lb_rvalid cyc %0d: got %b%b want %b%b", i, m0_rvalid, m1_rvalid, rv0m[i], rv1m[i]); end
      if (rv1m[i]) begin
        n_chk++; if (m1_rdata !== 32'hA000_0000 + nrv) begin n_fail++; $display("FAIL lb_rdata1 cyc %0d: got %h want %h", i, m1_rdata, 32'hA000_0000 + nrv); end
        nrv++;
      end
      if (rv0m[i]) begin
        n_chk++; if (m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lb_rdata0 cyc %0d: got %h want deadbeef", i, m0_rdata); end
      end
    end
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    mem[16] = 32'h1111_1111;
    mem[17] = 32'h1111_1111;
    m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h5555_0000;
    cyc();
    n_chk++; if (m0_gnt !== 1'b1 || ram_we !== 1'b1) begin n_fail++; $display("FAIL rmb_first: got g=%b we=%b want 1 1", m0_gnt, ram_we); end
    cyc();
    m0_addr = 32'h44; m0_wdata = 32'h5555_0001;
    n_chk++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rmb_second_gnt: got %b want 1", m0_gnt); end
    rst = 1'b1;
    #1;
    n_chk++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rmb_we_gate: got %b want 0", ram_we); end
    cyc();
    rst = 1'b0;
    m0_req = 1'b0; m0_lock = 1'b0; m0_we = 1'b0;
    n_chk++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmb_rvalid: got %b want 0", m0_rvalid); end
    n_chk++; if (mem[17] !== 32'h1111_1111) begin n_fail++; $display("FAIL rmb_mem_kept: got %h want 11111111", mem[17]); end
    n_chk++; if (mem[16] !== 32'h5555_0000) begin n_fail++; $display("FAIL rmb_mem_first: got %h want 55550000", mem[16]); end
    n_chk++; if (dut.last_q !== 1'b1 || dut.cnt_q !== 3'd0) begin n_fail++; $display("FAIL rmb_regs: got last=%b cnt=%0d want last=1 cnt=0", dut.last_q, dut.cnt_q); end
    n_chk++; if (m0_gnt !== 1'b0 || ram_addr !== 32'h0) begin n_fail++; $display("FAIL rmb_idle: got g=%b a=%h want g=0 a=0", m0_gnt, ram_addr); end
    cyc();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[64] = 32'hDEADBEEF;
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_read();
    test_locked_burst();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
